// File: rtl/change_dispenser.sv
// Change dispenser: splits a requested amount into 500/100 coins, largest first,
// and drives one hopper solenoid at a time with fixed pulse and gap timing.
module change_dispenser #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int MAX_AMOUNT   = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] amount,
    input  logic        empty_100,
    input  logic        empty_500,
    output logic        dispense_100,
    output logic        dispense_500,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [10:0] remaining
);

    localparam int TIMER_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW        = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [10:0]   MAX_AMT    = 11'(MAX_AMOUNT);
    localparam logic [10:0]   COIN_100   = 11'd100;
    localparam logic [10:0]   COIN_500   = 11'd500;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SELECT,
        PULSE,
        GAP,
        DONE,
        ERR
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [10:0]   remaining_q, remaining_d;
    logic          coin_500_q, coin_500_d;
    logic          dispense_100_q, dispense_100_d;
    logic          dispense_500_q, dispense_500_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    // The single timer is reloaded on entry to PULSE and GAP and counts down to zero.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        coin_500_d  = coin_500_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = amount;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if ((remaining_q > MAX_AMT) || ((remaining_q % COIN_100) != 11'd0)) begin
                    state_d = ERR;
                end else begin
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (remaining_q == 11'd0) begin
                    state_d = DONE;
                end else if ((remaining_q >= COIN_500) && !empty_500) begin
                    coin_500_d = 1'b1;
                    timer_d    = PULSE_LOAD;
                    state_d    = PULSE;
                end else if (!empty_100) begin
                    coin_500_d = 1'b0;
                    timer_d    = PULSE_LOAD;
                    state_d    = PULSE;
                end else begin
                    state_d = ERR;
                end
            end
            PULSE: begin
                if (timer_q == '0) begin
                    remaining_d = remaining_q - (coin_500_q ? COIN_500 : COIN_100);
                    timer_d     = GAP_LOAD;
                    state_d     = GAP;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            GAP: begin
                if (timer_q == '0) begin
                    state_d = SELECT;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        dispense_100_d = (state_d == PULSE) && !coin_500_d;
        dispense_500_d = (state_d == PULSE) && coin_500_d;
        busy_d         = (state_d != IDLE);
        done_d         = (state_d == DONE);
        error_d        = (state_d == ERR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            remaining_q    <= '0;
            coin_500_q     <= 1'b0;
            dispense_100_q <= 1'b0;
            dispense_500_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            remaining_q    <= remaining_d;
            coin_500_q     <= coin_500_d;
            dispense_100_q <= dispense_100_d;
            dispense_500_q <= dispense_500_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign dispense_100 = dispense_100_q;
    assign dispense_500 = dispense_500_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign remaining    = remaining_q;

    // Both solenoids energised together would jam the coin chute.
    assert property (@(posedge clk) disable iff (reset) !(dispense_100_q && dispense_500_q));

endmodule

// File: tb/tb_change_dispenser.sv
// Randomised scoreboard bench for change_dispenser: a coin-level reference model
// predicts pulse/strobe events and a monitor checks them as the DUT presents them.
module tb_change_dispenser;

    localparam int PULSE_CYCLES = 4;
    localparam int GAP_CYCLES   = 4;
    localparam int MAX_AMOUNT   = 2000;
    localparam int COIN_CYCLES  = 1 + PULSE_CYCLES + GAP_CYCLES;

    localparam int EV_100  = 0;
    localparam int EV_500  = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] amount;
    logic        empty_100;
    logic        empty_500;
    logic        dispense_100;
    logic        dispense_500;
    logic        busy;
    logic        done;
    logic        error;
    logic [10:0] remaining;

    change_dispenser #(
        .PULSE_CYCLES(PULSE_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES),
        .MAX_AMOUNT  (MAX_AMOUNT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .amount      (amount),
        .empty_100   (empty_100),
        .empty_500   (empty_500),
        .dispense_100(dispense_100),
        .dispense_500(dispense_500),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .remaining   (remaining)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int cycle;
        int rem;
    } event_t;

    event_t exp_q[$];
    int     checks = 0;
    int     errors = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d required %0d at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    task automatic push_event(input int kind, input int cycle, input int rem);
        event_t e;
        e.kind  = kind;
        e.cycle = cycle;
        e.rem   = rem;
        exp_q.push_back(e);
    endtask

    // Coin-by-coin payout: start sampled at edge n; the empty_100 level flips to
    // e100_post from coin index switch_coin onward (switch_coin < 0: never).
    task automatic model_request(input int n, input int amt, input bit e500,
                                 input bit e100_pre, input bit e100_post, input int switch_coin,
                                 output int end_cycle, output int final_rem);
        int rem;
        int i;
        int sel_cycle;
        bit e100;
        bit finished;
        rem = amt;
        if (amt > MAX_AMOUNT || (amt % 100) != 0) begin
            push_event(EV_ERR, n + 2, amt);
            end_cycle = n + 2;
            final_rem = amt;
            return;
        end
        i        = 0;
        finished = 1'b0;
        end_cycle = 0;
        while (!finished) begin
            sel_cycle = n + 2 + i * COIN_CYCLES;
            e100 = (switch_coin >= 0 && i >= switch_coin) ? e100_post : e100_pre;
            if (rem == 0) begin
                push_event(EV_DONE, sel_cycle + 1, 0);
                end_cycle = sel_cycle + 1;
                finished  = 1'b1;
            end else if (rem >= 500 && !e500) begin
                push_event(EV_500, sel_cycle + 1, rem);
                rem = rem - 500;
            end else if (!e100) begin
                push_event(EV_100, sel_cycle + 1, rem);
                rem = rem - 100;
            end else begin
                push_event(EV_ERR, sel_cycle + 1, rem);
                end_cycle = sel_cycle + 1;
                finished  = 1'b1;
            end
            i++;
        end
        final_rem = rem;
    endtask

    // Called at a falling edge; returns at a falling edge idle_gap cycles after
    // the first IDLE cycle following the terminal strobe.
    task automatic apply_stimulus(input int amt, input bit e500, input bit e100,
                                  input int switch_coin, input bit repulse, input int idle_gap);
        int n;
        int end_cycle;
        int final_rem;
        int toggle_cycle;
        start     = 1'b1;
        amount    = 11'(amt);
        empty_500 = e500;
        empty_100 = e100;
        n         = cyc;
        model_request(n, amt, e500, e100, !e100, switch_coin, end_cycle, final_rem);
        toggle_cycle = n + 3 + (switch_coin - 1) * COIN_CYCLES + PULSE_CYCLES + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < end_cycle + 1) begin
            @(negedge clk);
            if (repulse && end_cycle > n + 7) begin
                if (cyc == n + 5) begin
                    start  = 1'b1;
                    amount = 11'($urandom_range(0, 2047));
                end else if (cyc == n + 6) begin
                    start = 1'b0;
                end
            end
            if (switch_coin > 0 && cyc == toggle_cycle) empty_100 = !e100;
        end
        check_output("remaining_after", 32'(remaining), 32'(final_rem));
        repeat (idle_gap) @(negedge clk);
    endtask

    // Monitor: pops an expected event whenever a pulse begins or a strobe appears.
    initial begin : monitor
        bit     prev100 = 1'b0;
        bit     prev500 = 1'b0;
        bit     strobe_prev = 1'b0;
        int     len = 0;
        int     kind;
        event_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev100     = 1'b0;
                prev500     = 1'b0;
                strobe_prev = 1'b0;
                len         = 0;
                continue;
            end
            if (dispense_100 || dispense_500)
                check_output("one_hopper", 32'(dispense_100 & dispense_500), 32'd0);
            if (done || error)
                check_output("strobe_exclusive", 32'(done & error), 32'd0);
            kind = -1;
            if (dispense_100 && !prev100)      kind = EV_100;
            else if (dispense_500 && !prev500) kind = EV_500;
            else if (done)                     kind = EV_DONE;
            else if (error)                    kind = EV_ERR;
            if (kind >= 0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_event: got kind %0d at cycle %0d, required none", kind, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check_output("event_kind", kind, e.kind);
                    check_output("event_cycle", cyc, e.cycle);
                    check_output("event_remaining", 32'(remaining), e.rem);
                    if (kind >= EV_DONE) check_output("busy_at_strobe", 32'(busy), 32'd1);
                end
            end
            if (strobe_prev) check_output("busy_after_strobe", 32'(busy), 32'd0);
            strobe_prev = done || error;
            if (dispense_100 || dispense_500) begin
                len++;
            end else begin
                if (prev100 || prev500) check_output("pulse_length", len, PULSE_CYCLES);
                len = 0;
            end
            prev100 = dispense_100;
            prev500 = dispense_500;
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        int n;
        int amt;
        int sw;
        reset     = 1'b1;
        start     = 1'b0;
        amount    = '0;
        empty_100 = 1'b0;
        empty_500 = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_dispense_100", 32'(dispense_100), 32'd0);
        check_output("reset_dispense_500", 32'(dispense_500), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_error", 32'(error), 32'd0);
        check_output("reset_remaining", 32'(remaining), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        apply_stimulus(800, 1'b0, 1'b0, -1, 1'b0, 0);
        apply_stimulus(1000, 1'b1, 1'b0, -1, 1'b1, 0);
        apply_stimulus(250, 1'b0, 1'b0, -1, 1'b0, 2);
        check_output("error_hold_remaining", 32'(remaining), 32'd250);
        apply_stimulus(2047, 1'b0, 1'b0, -1, 1'b0, 1);
        apply_stimulus(2000, 1'b0, 1'b0, -1, 1'b0, 0);
        apply_stimulus(300, 1'b0, 1'b0, 1, 1'b0, 1);
        check_output("hopper_empty_hold", 32'(remaining), 32'd200);
        apply_stimulus(0, 1'b0, 1'b0, -1, 1'b0, 0);
        apply_stimulus(700, 1'b0, 1'b1, -1, 1'b0, 0);

        // Reset during the second cycle of a 500 pulse.
        start     = 1'b1;
        amount    = 11'd800;
        empty_100 = 1'b0;
        empty_500 = 1'b0;
        n         = cyc;
        push_event(EV_500, n + 3, 800);
        @(negedge clk);
        start = 1'b0;
        while (cyc < n + 4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_output("reset_mid_pulse_500", 32'(dispense_500), 32'd0);
        check_output("reset_mid_pulse_100", 32'(dispense_100), 32'd0);
        check_output("reset_mid_pulse_busy", 32'(busy), 32'd0);
        check_output("reset_mid_pulse_remaining", 32'(remaining), 32'd0);
        check_output("reset_pulse_seen", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (12) @(negedge clk);
        check_output("post_reset_busy", 32'(busy), 32'd0);

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 9) < 7) amt = $urandom_range(0, 20) * 100;
            else                          amt = $urandom_range(0, 2047);
            sw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : -1;
            apply_stimulus(amt, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                           sw, $urandom_range(0, 1) == 1, $urandom_range(0, 3));
        end

        repeat (5) @(negedge clk);
        check_output("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
